aplic_msi_notifier: RTL and testbench

- Downstream of the APLIC domain register file, for domains with domaincfg.DM = MSI.
- Scans the pending and enabled sources round-robin and reads each hit's target register.
- Builds the MSI address from the msiaddrcfg fields and issues one write per interrupt on a valid/ready port; clears the source's pending bit on acceptance.
- Also services the genmsi register with the same write port.

---
 rtl/aplic_msi_notifier_if.sv | 10 +
 rtl/aplic_msi_notifier.sv | 164 ++++++++++++++++
 tb/tb_aplic_msi_notifier.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aplic_msi_notifier_if.sv
// MSI write request channel: one address/data write per valid/ready handshake.
interface aplic_msi_notifier_if;
    logic        valid;
    logic [63:0] addr;
    logic [31:0] data;
    logic        ready;

    modport master (output valid, addr, data, input ready);
    modport slave  (input valid, addr, data, output ready);
endinterface

// File: rtl/aplic_msi_notifier.sv
// APLIC MSI-mode notifier: round-robin scan of pending/enabled sources and genmsi,
// each turned into a single MSI write; the source's pending bit is cleared on acceptance.
module aplic_msi_notifier #(
    parameter int NR_SRC   = 32,
    parameter int NR_SRC_W = $clog2(NR_SRC)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_domaincfg_ie,
    input  logic                 i_domaincfg_dm,
    input  logic [NR_SRC-1:0]    i_ip,
    input  logic [NR_SRC-1:0]    i_ie,
    output logic [NR_SRC_W-1:0]  o_tgt_idx,
    input  logic [31:0]          i_target,
    input  logic [43:0]          i_base_ppn,
    input  logic [2:0]           i_lhxs,
    input  logic [3:0]           i_lhxw,
    input  logic [4:0]           i_hhxs,
    input  logic [2:0]           i_hhxw,
    input  logic                 i_genmsi_we,
    input  logic [13:0]          i_genmsi_hi,
    input  logic [10:0]          i_genmsi_eiid,
    output logic                 o_genmsi_busy,
    aplic_msi_notifier_if.master msi,
    output logic                 o_clrip_valid,
    output logic [NR_SRC_W-1:0]  o_clrip_idx
);

    typedef enum logic [1:0] {SCAN, LOAD, SEND} state_t;

    state_t                state_q, state_d;
    logic [NR_SRC_W-1:0]   ptr_q, ptr_d;
    logic [NR_SRC_W-1:0]   cur_q, cur_d;
    logic                  src_q, src_d;
    logic [63:0]           addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic                  clrip_q, clrip_d;
    logic [NR_SRC_W-1:0]   clrip_idx_q, clrip_idx_d;
    logic                  busy_q, busy_clr;
    logic [13:0]           genmsi_hi_q;
    logic [10:0]           genmsi_eiid_q;
    logic                  hit;
    logic                  unused_target_bit;

    assign unused_target_bit = i_target[11];

    function automatic logic [NR_SRC_W-1:0] wrap_next(input logic [NR_SRC_W-1:0] idx);
        return (idx == NR_SRC_W'(NR_SRC - 1)) ? NR_SRC_W'(1) : idx + NR_SRC_W'(1);
    endfunction

    // PPN = base | group << (HHXS+12) | hart << LHXS | guest, then shifted to a byte address.
    function automatic logic [63:0] build_addr(input logic [13:0] hi, input logic [5:0] gi);
        logic [43:0] hi_w, g, h, ppn;
        hi_w = 44'(hi);
        g    = (hi_w >> i_lhxw) & ((44'd1 << i_hhxw) - 44'd1);
        h    = hi_w & ((44'd1 << i_lhxw) - 44'd1);
        ppn  = i_base_ppn | (g << (6'(i_hhxs) + 6'd12)) | (h << i_lhxs) | 44'(gi);
        return {8'd0, ppn, 12'd0};
    endfunction

    assign hit = i_domaincfg_dm & i_domaincfg_ie & i_ip[ptr_q] & i_ie[ptr_q];

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cur_d       = cur_q;
        src_d       = src_q;
        addr_d      = addr_q;
        data_d      = data_q;
        clrip_d     = 1'b0;
        clrip_idx_d = clrip_idx_q;
        busy_clr    = 1'b0;
        case (state_q)
            SCAN: begin
                if (busy_q) begin
                    addr_d  = build_addr(genmsi_hi_q, 6'd0);
                    data_d  = 32'(genmsi_eiid_q);
                    src_d   = 1'b0;
                    state_d = SEND;
                end else if (hit) begin
                    cur_d   = ptr_q;
                    state_d = LOAD;
                end else begin
                    ptr_d = wrap_next(ptr_q);
                end
            end
            LOAD: begin
                if (!(i_ip[cur_q] & i_ie[cur_q] & i_domaincfg_ie)) begin
                    ptr_d   = wrap_next(cur_q);
                    state_d = SCAN;
                end else if (i_target[10:0] == 11'd0) begin
                    clrip_d     = 1'b1;
                    clrip_idx_d = cur_q;
                    ptr_d       = wrap_next(cur_q);
                    state_d     = SCAN;
                end else begin
                    addr_d  = build_addr(i_target[31:18], i_target[17:12]);
                    data_d  = 32'(i_target[10:0]);
                    src_d   = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (msi.ready) begin
                    state_d = SCAN;
                    if (src_q) begin
                        clrip_d     = 1'b1;
                        clrip_idx_d = cur_q;
                        ptr_d       = wrap_next(cur_q);
                    end else begin
                        busy_clr = 1'b1;
                    end
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= SCAN;
            ptr_q       <= NR_SRC_W'(1);
            cur_q       <= '0;
            src_q       <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            clrip_q     <= 1'b0;
            clrip_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cur_q       <= cur_d;
            src_q       <= src_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            clrip_q     <= clrip_d;
            clrip_idx_q <= clrip_idx_d;
        end
    end

    // A write strobe arriving while busy is dropped, so the in-flight payload stays intact.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            busy_q        <= 1'b0;
            genmsi_hi_q   <= '0;
            genmsi_eiid_q <= '0;
        end else if (busy_clr) begin
            busy_q <= 1'b0;
        end else if (i_genmsi_we && !busy_q) begin
            busy_q        <= 1'b1;
            genmsi_hi_q   <= i_genmsi_hi;
            genmsi_eiid_q <= i_genmsi_eiid;
        end
    end

    assign o_tgt_idx     = cur_q;
    assign o_genmsi_busy = busy_q;
    assign msi.valid     = (state_q == SEND);
    assign msi.addr      = addr_q;
    assign msi.data      = data_q;
    assign o_clrip_valid = clrip_q;
    assign o_clrip_idx   = clrip_idx_q;

endmodule

// File: tb/tb_aplic_msi_notifier.sv
// Directed bench for aplic_msi_notifier: expected MSI writes and pending-bit clears
// are queued when stimulus is applied and compared when the DUT produces them.
module tb_aplic_msi_notifier;
    localparam int NR = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        dm, die;
    logic [31:0] ip, ie;
    logic [4:0]  tgt_idx;
    logic [31:0] target;
    logic [43:0] base;
    logic [2:0]  lhxs;
    logic [3:0]  lhxw;
    logic [4:0]  hhxs;
    logic [2:0]  hhxw;
    logic        gwe;
    logic [13:0] ghi;
    logic [10:0] geiid;
    logic        gbusy;
    logic        clr_v;
    logic [4:0]  clr_idx;
    logic        ready_en;
    logic [31:0] tgt_mem [NR];

    logic [95:0] wr_q [$];
    logic [4:0]  clr_q [$];
    int          n_vec = 0;
    int          n_err = 0;
    int          n_wr  = 0;
    int          wr0;
    logic [63:0] exp_a;

    always #5 clk = ~clk;

    assign target = tgt_mem[tgt_idx];

    aplic_msi_notifier_if bus ();

    aplic_msi_notifier #(.NR_SRC(NR), .NR_SRC_W(5)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_domaincfg_ie (die),
        .i_domaincfg_dm (dm),
        .i_ip           (ip),
        .i_ie           (ie),
        .o_tgt_idx      (tgt_idx),
        .i_target       (target),
        .i_base_ppn     (base),
        .i_lhxs         (lhxs),
        .i_lhxw         (lhxw),
        .i_hhxs         (hhxs),
        .i_hhxw         (hhxw),
        .i_genmsi_we    (gwe),
        .i_genmsi_hi    (ghi),
        .i_genmsi_eiid  (geiid),
        .o_genmsi_busy  (gbusy),
        .msi            (bus),
        .o_clrip_valid  (clr_v),
        .o_clrip_idx    (clr_idx)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_tgt(input logic [13:0] hi, input logic [5:0] gi,
                                           input logic [10:0] eiid);
        return {hi, gi, 1'b0, eiid};
    endfunction

    function automatic logic [63:0] model_addr(input logic [13:0] hi, input logic [5:0] gi);
        longint unsigned hv, g, h, ppn;
        hv  = 64'(hi);
        g   = (hv >> lhxw) % (64'd1 << hhxw);
        h   = hv % (64'd1 << lhxw);
        ppn = 64'(base) | (g << (hhxs + 12)) | (h << lhxs) | 64'(gi);
        ppn = ppn & 64'h0000_0FFF_FFFF_FFFF;
        return ppn << 12;
    endfunction

    task automatic push_wr(input logic [13:0] hi, input logic [5:0] gi, input logic [10:0] eiid);
        wr_q.push_back({model_addr(hi, gi), 32'(eiid)});
    endtask

    task automatic tick();
        logic [95:0] e;
        logic [4:0]  c;
        @(negedge clk);
        if (clr_v) begin
            if (clr_q.size() == 0) check("clrip_unexpected", 64'(clr_v), 64'd0);
            else begin
                c = clr_q.pop_front();
                check("clrip_idx", 64'(clr_idx), 64'(c));
            end
            ip[clr_idx] = 1'b0;
        end
        bus.ready = ready_en;
        if (bus.valid && bus.ready) begin
            n_wr++;
            if (wr_q.size() == 0) check("msi_unexpected", 64'(bus.valid), 64'd0);
            else begin
                e = wr_q.pop_front();
                check("msi_addr", bus.addr, e[95:32]);
                check("msi_data", 64'(bus.data), 64'(e[31:0]));
            end
        end
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while ((wr_q.size() != 0 || clr_q.size() != 0) && n < max) begin
            tick();
            n++;
        end
        check({tag, "_drained"}, 64'(wr_q.size() + clr_q.size()), 64'd0);
    endtask

    task automatic wait_valid(input string tag, input int max);
        int n = 0;
        while (!bus.valid && n < max) begin
            tick();
            n++;
        end
        check({tag, "_valid_seen"}, 64'(bus.valid), 64'd1);
    endtask

    initial begin
        rst = 1'b1; dm = 1'b1; die = 1'b1; ip = '0; ie = '1;
        base = 44'h80000; lhxs = 3'd0; lhxw = 4'd2; hhxs = 5'd0; hhxw = 3'd0;
        gwe = 1'b0; ghi = '0; geiid = '0; ready_en = 1'b1; bus.ready = 1'b0;
        for (int i = 0; i < NR; i++) tgt_mem[i] = '0;
        repeat (3) tick();

        check("rst_valid", 64'(bus.valid), 64'd0);
        check("rst_clrip", 64'(clr_v), 64'd0);
        check("rst_busy", 64'(gbusy), 64'd0);
        check("rst_tgt_idx", 64'(tgt_idx), 64'd0);
        check("rst_addr", bus.addr, 64'd0);
        check("rst_data", 64'(bus.data), 64'd0);

        // Single source 5; after reset ptr starts at 1, so the hit lands on the 5th edge
        tgt_mem[5] = mk_tgt(14'd3, 6'd2, 11'h2A);
        ip[5] = 1'b1;
        push_wr(14'd3, 6'd2, 11'h2A);
        clr_q.push_back(5'd5);
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("lat_src_idle", 64'(bus.valid), 64'd0);
        end
        check("load_tgt_idx", 64'(tgt_idx), 64'd5);
        tick();
        check("lat_src_valid", 64'(bus.valid), 64'd1);
        tick();
        check("clrip_pulse", 64'(clr_v), 64'd1);
        tick();
        check("clrip_one_cycle", 64'(clr_v), 64'd0);

        // Backpressure with ip and base_ppn changing under a held request
        ready_en = 1'b0;
        ip[5] = 1'b1;
        exp_a = model_addr(14'd3, 6'd2);
        push_wr(14'd3, 6'd2, 11'h2A);
        clr_q.push_back(5'd5);
        wr0 = n_wr;
        wait_valid("bp", 64);
        for (int k = 0; k < 10; k++) begin
            ip[5] = ~ip[5];
            base = base ^ 44'h1F000;
            tick();
            check("bp_valid", 64'(bus.valid), 64'd1);
            check("bp_addr", bus.addr, exp_a);
            check("bp_data", 64'(bus.data), 64'h2A);
        end
        base = 44'h80000;
        ready_en = 1'b1;
        wait_idle("bp", 16);
        repeat (4) tick();
        check("bp_one_write", 64'(n_wr - wr0), 64'd1);

        // Wrap: ptr is past 1, so 31 is served before 1
        tgt_mem[31] = mk_tgt(14'd1, 6'd0, 11'h031);
        tgt_mem[1]  = mk_tgt(14'd2, 6'd1, 11'h101);
        ip[31] = 1'b1;
        ip[1]  = 1'b1;
        push_wr(14'd1, 6'd0, 11'h031);
        push_wr(14'd2, 6'd1, 11'h101);
        clr_q.push_back(5'd31);
        clr_q.push_back(5'd1);
        wait_idle("rr", 100);

        // EIID zero: clear only, no write
        tgt_mem[7] = mk_tgt(14'd4, 6'd0, 11'd0);
        ip[7] = 1'b1;
        clr_q.push_back(5'd7);
        wait_idle("eiid0", 64);
        repeat (3) tick();

        // genmsi ahead of a pending source; a second strobe while busy is dropped
        ready_en = 1'b0;
        tgt_mem[4] = mk_tgt(14'd5, 6'd3, 11'h044);
        ip[4] = 1'b1;
        gwe = 1'b1; ghi = 14'd1; geiid = 11'd9;
        push_wr(14'd1, 6'd0, 11'd9);
        push_wr(14'd5, 6'd3, 11'h044);
        clr_q.push_back(5'd4);
        tick();
        gwe = 1'b1; ghi = 14'd5; geiid = 11'd7;
        check("gen_busy_set", 64'(gbusy), 64'd1);
        check("gen_lat_idle", 64'(bus.valid), 64'd0);
        tick();
        gwe = 1'b0;
        check("gen_lat_valid", 64'(bus.valid), 64'd1);
        check("gen_addr", bus.addr, model_addr(14'd1, 6'd0));
        check("gen_data", 64'(bus.data), 64'd9);
        repeat (3) tick();
        check("gen_busy_held", 64'(gbusy), 64'd1);
        ready_en = 1'b1;
        tick();
        tick();
        check("gen_busy_clear", 64'(gbusy), 64'd0);
        wait_idle("gen", 100);

        // Abort in LOAD: ptr is 5 here, so source 6 is in LOAD after two edges
        tgt_mem[6] = mk_tgt(14'd0, 6'd0, 11'h066);
        tgt_mem[7] = mk_tgt(14'd0, 6'd0, 11'h077);
        ip[6] = 1'b1;
        tick();
        tick();
        ip[6] = 1'b0;
        ip[7] = 1'b1;
        tick();
        check("abort_no_send", 64'(bus.valid), 64'd0);
        ip[6] = 1'b1;
        push_wr(14'd0, 6'd0, 11'h077);
        push_wr(14'd0, 6'd0, 11'h066);
        clr_q.push_back(5'd7);
        clr_q.push_back(5'd6);
        wait_idle("abort", 100);

        // Reset during SEND drops the request asynchronously
        ready_en = 1'b0;
        tgt_mem[9] = mk_tgt(14'd0, 6'd0, 11'h099);
        ip[9] = 1'b1;
        wait_valid("rstsend", 64);
        #2 rst = 1'b1;
        #1;
        check("rst_async_valid", 64'(bus.valid), 64'd0);
        check("rst_async_addr", bus.addr, 64'd0);
        check("rst_async_clrip", 64'(clr_v), 64'd0);
        tick();
        rst = 1'b0;
        ready_en = 1'b1;
        push_wr(14'd0, 6'd0, 11'h099);
        clr_q.push_back(5'd9);
        for (int k = 1; k <= 9; k++) begin
            tick();
            check("rst_rescan_idle", 64'(bus.valid), 64'd0);
        end
        tick();
        check("rst_rescan_valid", 64'(bus.valid), 64'd1);
        wait_idle("rstsend", 16);

        // DM = 0: sources ignored, genmsi with eiid 0 still written
        dm = 1'b0;
        tgt_mem[10] = mk_tgt(14'd0, 6'd0, 11'h010);
        ip[10] = 1'b1;
        gwe = 1'b1; ghi = 14'd2; geiid = 11'd0;
        push_wr(14'd2, 6'd0, 11'd0);
        tick();
        gwe = 1'b0;
        wait_idle("dm0", 16);
        repeat (70) tick();
        check("dm0_busy", 64'(gbusy), 64'd0);
        check("dm0_writes_left", 64'(wr_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
